// File: rtl/axi_tx.sv
// rtl/axi_tx.sv - AXI-Stream master transmitter with input FIFO; AXI_TX_PAD_EN adds min-frame zero padding
module axi_tx #(
   parameter int DATA_WIDTH      = 64,
   parameter int FIFO_DEPTH      = 8,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_WIDTH-1:0]             tdata_in,
   input  logic [$clog2(DATA_WIDTH/8+1)-1:0] idx_in,
   input  logic                              data_valid_in,
   input  logic                              last_flag_in,
   output logic                              tx_ready,
   output logic                              tvalid,
   output logic [DATA_WIDTH-1:0]             tdata,
   output logic [DATA_WIDTH/8-1:0]           tkeep,
   output logic                              tlast,
   input  logic                              tready,
   output logic [31:0]                       frames_sent,
   output logic                              overflow
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = $clog2(NB + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   function automatic logic [NB-1:0] keep_of(input logic [15:0] n);
      logic [NB-1:0] k;
      k = '0;
      for (int b = 0; b < NB; b++)
         if (16'(b) < n) k[b] = 1'b1;
      return k;
   endfunction

   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [IW-1:0]         mem_idx  [FIFO_DEPTH];
   logic                  mem_last [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;

   logic [IW-1:0]         idx_c;
   logic [NB-1:0]         in_keep;
   logic [DATA_WIDTH-1:0] data_m;
   logic                  push, pop, head_valid, head_last;
   logic [DATA_WIDTH-1:0] head_data;
   logic [IW-1:0]         head_idx;

   assign tx_ready   = (count < CW'(FIFO_DEPTH));
   assign push       = data_valid_in & tx_ready;
   assign head_valid = (count != '0);
   assign head_data  = mem_data[rd_ptr];
   assign head_idx   = mem_idx[rd_ptr];
   assign head_last  = mem_last[rd_ptr];

   // Bytes past the valid count are zeroed on entry so pad beats need no extra masking
   always_comb begin
      idx_c   = (idx_in > IW'(NB)) ? IW'(NB) : idx_in;
      in_keep = keep_of(16'(idx_c));
      data_m  = '0;
      for (int b = 0; b < NB; b++)
         if (in_keep[b]) data_m[8*b +: 8] = tdata_in[8*b +: 8];
   end

`ifdef AXI_TX_PAD_EN
   typedef enum logic {PASS, PAD} state_t;
   localparam logic [16:0] MIN17 = 17'(MIN_FRAME_BYTES);
   localparam logic [15:0] MIN16 = 16'(MIN_FRAME_BYTES);

   state_t      state;
   logic [15:0] out_bytes, rem, beat_bytes;
   logic [16:0] sum_last, sum_out;
   logic        is_short;

   always_comb begin
      tvalid     = 1'b0;
      tdata      = '0;
      tkeep      = '0;
      tlast      = 1'b0;
      pop        = 1'b0;
      beat_bytes = '0;
      sum_last   = {1'b0, out_bytes} + 17'(head_idx);
      is_short   = head_last && (sum_last < MIN17);
      rem        = (out_bytes >= MIN16) ? 16'd0 : (MIN16 - out_bytes);
      if (state == PASS) begin
         if (head_valid) begin
            tvalid = 1'b1;
            tdata  = head_data;
            pop    = tready;
            if (is_short) begin
               tkeep      = '1;
               beat_bytes = 16'(NB);
            end else begin
               tkeep      = keep_of(16'(head_idx));
               tlast      = head_last;
               beat_bytes = 16'(head_idx);
            end
         end
      end else begin
         tvalid = 1'b1;
         if (rem > 16'(NB)) begin
            tkeep      = '1;
            beat_bytes = 16'(NB);
         end else begin
            tkeep      = keep_of(rem);
            tlast      = 1'b1;
            beat_bytes = rem;
         end
      end
      sum_out = {1'b0, out_bytes} + {1'b0, beat_bytes};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PASS;
         out_bytes <= '0;
      end else if (tvalid && tready) begin
         if (tlast) begin
            state     <= PASS;
            out_bytes <= '0;
         end else begin
            out_bytes <= sum_out[16] ? 16'hFFFF : sum_out[15:0];
            if (state == PASS && head_last) state <= PAD;
         end
      end
   end
`else
   always_comb begin
      tvalid = head_valid;
      tdata  = head_valid ? head_data : '0;
      tkeep  = head_valid ? keep_of(16'(head_idx)) : '0;
      tlast  = head_valid & head_last;
      pop    = head_valid & tready;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         frames_sent <= '0;
         overflow    <= 1'b0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= data_m;
            mem_idx[wr_ptr]  <= idx_c;
            mem_last[wr_ptr] <= last_flag_in;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (data_valid_in && !tx_ready) overflow <= 1'b1;
         if (tvalid && tready && tlast) frames_sent <= frames_sent + 32'd1;
      end
   end

endmodule

// File: tb/tb_axi_tx.sv
// tb/tb_axi_tx.sv - scoreboard bench for axi_tx, default build or AXI_TX_PAD_EN
module tb_axi_tx;

   localparam int NB  = 8;
   localparam int MIN = 60;
`ifdef AXI_TX_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] tdata_in = '0;
   logic [3:0]  idx_in = '0;
   logic        data_valid_in = 1'b0;
   logic        last_flag_in = 1'b0;
   logic        tx_ready, tvalid, tlast, overflow;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tready = 1'b0;
   logic [31:0] frames_sent;

   beat_t       sb[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          beats = 0;
   int          ob = 0;

   axi_tx dut (
      .clk(clk), .rst(rst), .tdata_in(tdata_in), .idx_in(idx_in),
      .data_valid_in(data_valid_in), .last_flag_in(last_flag_in),
      .tx_ready(tx_ready), .tvalid(tvalid), .tdata(tdata), .tkeep(tkeep),
      .tlast(tlast), .tready(tready), .frames_sent(frames_sent), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [7:0] keep_of(input int n);
      logic [7:0] k;
      k = '0;
      for (int b = 0; b < NB; b++)
         if (b < n) k[b] = 1'b1;
      return k;
   endfunction

   function automatic logic [63:0] mask(input logic [63:0] d, input logic [7:0] k);
      logic [63:0] m;
      m = '0;
      for (int b = 0; b < NB; b++)
         if (k[b]) m[8*b +: 8] = d[8*b +: 8];
      return m;
   endfunction

   task automatic model_word(input logic [63:0] d, input int idx, input logic last);
      int          n;
      int          rem;
      bit          done;
      logic [7:0]  k;
      n = (idx > NB) ? NB : idx;
      k = keep_of(n);
      if (PAD && last && (ob + n < MIN)) begin
         sb.push_back('{d: mask(d, k), k: 8'hFF, l: 1'b0});
         ob += NB;
         done = 1'b0;
         for (int i = 0; i < 16 && !done; i++) begin
            rem = (ob >= MIN) ? 0 : MIN - ob;
            if (rem > NB) begin
               sb.push_back('{d: 64'd0, k: 8'hFF, l: 1'b0});
               ob += NB;
            end else begin
               sb.push_back('{d: 64'd0, k: keep_of(rem), l: 1'b1});
               ob = 0;
               done = 1'b1;
            end
         end
      end else begin
         sb.push_back('{d: mask(d, k), k: k, l: last});
         ob = last ? 0 : ob + n;
      end
   endtask

   task automatic put(input logic [63:0] d, input int idx, input logic last);
      int t = 0;
      while (!tx_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!tx_ready) check("tx_ready_wait", 64'(tx_ready), 64'd1);
      tdata_in      = d;
      idx_in        = 4'(idx);
      last_flag_in  = last;
      data_valid_in = 1'b1;
      model_word(d, idx, last);
      @(posedge clk); #1;
      data_valid_in = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Beats are compared at the negedge; a stalled beat must look identical one cycle later
   logic        prev_stall = 1'b0;
   logic [63:0] prev_d;
   logic [7:0]  prev_k;
   logic        prev_l;
   always @(negedge clk) begin
      beat_t e;
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            check("stall_data", tdata, prev_d);
            check("stall_ctl", 64'({tvalid, tkeep, tlast}), 64'({1'b1, prev_k, prev_l}));
         end
         if (tvalid && tready) begin
            check("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("beat_data", tdata, e.d);
               check("beat_keep", 64'(tkeep), 64'(e.k));
               check("beat_last", 64'(tlast), 64'(e.l));
            end
            beats++;
         end
         prev_stall = tvalid && !tready;
         prev_d = tdata;
         prev_k = tkeep;
         prev_l = tlast;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_tx_ready", 64'(tx_ready), 64'd1);
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tdata", tdata, 64'd0);
      check("rst_tkeep", 64'(tkeep), 64'd0);
      check("rst_tlast", 64'(tlast), 64'd0);
      check("rst_frames", 64'(frames_sent), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);

      tready = 1'b1;
      put(64'h0807060504030201, 8, 1'b1);
      drain();
      check("frames_single", 64'(frames_sent), 64'd1);

      b0 = beats;
      put(64'h1122334455667788, 8, 1'b0);
      put(64'hFFFFFFFFFFCCBBAA, 3, 1'b1);
      drain();
      check("partial_beats", 64'(beats - b0), PAD ? 64'd8 : 64'd2);
      check("frames_partial", 64'(frames_sent), 64'd2);

      tready = 1'b0;
      for (int i = 0; i < 8; i++)
         put({$urandom, $urandom}, (i == 3) ? 15 : 8, i == 7);
      check("full_tx_ready", 64'(tx_ready), 64'd0);
      check("full_tvalid", 64'(tvalid), 64'd1);
      tdata_in = 64'hDEADBEEFDEADBEEF;
      idx_in = 4'd8;
      last_flag_in = 1'b1;
      data_valid_in = 1'b1;
      @(posedge clk); #1;
      data_valid_in = 1'b0;
      check("overflow_set", 64'(overflow), 64'd1);
      repeat (4) @(posedge clk);
      #1 tready = 1'b1;
      drain();
      check("frames_full", 64'(frames_sent), 64'd3);
      check("overflow_sticky", 64'(overflow), 64'd1);

      tready = 1'b0;
      for (int i = 0; i < 8; i++)
         put({$urandom, $urandom}, 8, i == 7);
      check("refill_tx_ready", 64'(tx_ready), 64'd0);
      tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         put({$urandom, $urandom}, 8, i == 7);
         check("stream_tx_ready", 64'(tx_ready), 64'd1);
      end
      drain();
      check("frames_stream", 64'(frames_sent), 64'd5);

      b0 = beats;
      put(64'hA1A2A3A4A5A6A7A8, 8, 1'b0);
      put(64'hFFFF0F0E0D0C0B0A, 6, 1'b1);
      drain();
      check("pad_beats", 64'(beats - b0), PAD ? 64'd8 : 64'd2);
      check("frames_pad", 64'(frames_sent), 64'd6);

      tready = 1'b0;
      put({$urandom, $urandom}, 8, 1'b0);
      put({$urandom, $urandom}, 8, 1'b0);
      rst = 1'b1;
      sb.delete();
      ob = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_tvalid", 64'(tvalid), 64'd0);
      check("mid_rst_tx_ready", 64'(tx_ready), 64'd1);
      check("mid_rst_frames", 64'(frames_sent), 64'd0);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
      tready = 1'b1;
      b0 = beats;
      put(64'h0102030405060708, 8, 1'b1);
      drain();
      check("post_rst_beats", 64'(beats - b0), PAD ? 64'd8 : 64'd1);
      check("post_rst_frames", 64'(frames_sent), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
